object_bbox_tracker: RTL and testbench

- Sits directly downstream of connected-components labeling and consumes its per-pixel label stream together with the raster x/y coordinates.
- Maintains a bounding box (min/max x, min/y, max y) for every non-background label in the current frame.
- After the frame's last pixel, answers obj_id queries with the box centre. This replaces the constant obj_x/obj_y outputs at top level.

---
 rtl/object_bbox_tracker.sv | 161 ++++++++++++++++
 tb/tb_object_bbox_tracker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/object_bbox_tracker.sv
// Per-label bounding-box tracker behind CC labeling; 2-stage update pipe, query answered 1 clk after obj_id.
// No backpressure: accepts one pixel per clock whenever en is high, bubbles when en is low.
module object_bbox_tracker #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int LABEL_WIDTH  = 8,
    parameter int COORD_WIDTH  = 11
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [31:0]            x,
    input  logic [31:0]            y,
    input  logic [LABEL_WIDTH-1:0] label,
    input  logic [LABEL_WIDTH-1:0] obj_id,
    output logic                   frame_done,
    output logic                   obj_hit,
    output logic [31:0]            obj_x,
    output logic [31:0]            obj_y
);
    localparam int          N      = 1 << LABEL_WIDTH;
    localparam logic [31:0] W32    = 32'(FRAME_WIDTH);
    localparam logic [31:0] H32    = 32'(FRAME_HEIGHT);
    localparam logic [31:0] LAST_X = 32'(FRAME_WIDTH - 1);
    localparam logic [31:0] LAST_Y = 32'(FRAME_HEIGHT - 1);

    typedef struct packed {
        logic [COORD_WIDTH-1:0] min_x;
        logic [COORD_WIDTH-1:0] max_x;
        logic [COORD_WIDTH-1:0] min_y;
        logic [COORD_WIDTH-1:0] max_y;
    } box_t;

    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

    state_t                 r_state;
    logic                   r_frame_done;
    logic                   r_obj_hit;
    logic [31:0]            r_obj_x;
    logic [31:0]            r_obj_y;
    logic [N-1:0]           r_valid;
    box_t                   r_box_tbl [N];
    box_t                   r_s1_rd;
    logic                   r_s1_vld;
    logic [LABEL_WIDTH-1:0] r_s1_label;
    logic [COORD_WIDTH-1:0] r_s1_x;
    logic [COORD_WIDTH-1:0] r_s1_y;
    logic                   r_fwd_vld;
    logic [LABEL_WIDTH-1:0] r_fwd_label;
    box_t                   r_fwd_box;

    logic                   w_frame_start;
    logic                   w_last_pix;
    logic                   w_s0_vld;
    logic                   w_fwd_hit;
    logic                   w_old_vld;
    logic                   w_wr_en;
    box_t                   w_old;
    box_t                   w_new;
    box_t                   w_q_box;
    logic [COORD_WIDTH:0]   w_sum_x;
    logic [COORD_WIDTH:0]   w_sum_y;
    logic                   w_q_hit;

    assign w_frame_start = en && (x == 32'd0) && (y == 32'd0);
    assign w_last_pix    = en && (x == LAST_X) && (y == LAST_Y);
    // Full 32-bit bounds check so out-of-frame coordinates never alias after truncation.
    assign w_s0_vld      = en && (label != '0) && (x < W32) && (y < H32);

    assign w_fwd_hit = r_fwd_vld && (r_fwd_label == r_s1_label);
    assign w_old     = w_fwd_hit ? r_fwd_box : r_s1_rd;
    assign w_old_vld = w_fwd_hit || r_valid[r_s1_label];
    // A frame clear on the same edge wins over a leftover write from the previous frame.
    assign w_wr_en   = r_s1_vld && !w_frame_start;

    always_comb begin
        w_new = '{min_x: r_s1_x, max_x: r_s1_x, min_y: r_s1_y, max_y: r_s1_y};
        if (w_old_vld) begin
            w_new.min_x = (r_s1_x < w_old.min_x) ? r_s1_x : w_old.min_x;
            w_new.max_x = (r_s1_x > w_old.max_x) ? r_s1_x : w_old.max_x;
            w_new.min_y = (r_s1_y < w_old.min_y) ? r_s1_y : w_old.min_y;
            w_new.max_y = (r_s1_y > w_old.max_y) ? r_s1_y : w_old.max_y;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_box_tbl[r_s1_label] <= w_new;
        end
        r_s1_rd <= r_box_tbl[label];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_label  <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_valid     <= '0;
            r_fwd_vld   <= 1'b0;
            r_fwd_label <= '0;
            r_fwd_box   <= '0;
        end else begin
            r_s1_vld   <= w_s0_vld;
            r_s1_label <= label;
            r_s1_x     <= x[COORD_WIDTH-1:0];
            r_s1_y     <= y[COORD_WIDTH-1:0];
            if (w_frame_start) begin
                r_valid   <= '0;
                r_fwd_vld <= 1'b0;
            end else if (w_wr_en) begin
                r_valid[r_s1_label] <= 1'b1;
                r_fwd_vld           <= 1'b1;
                r_fwd_label         <= r_s1_label;
                r_fwd_box           <= w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ACCUM;
            r_frame_done <= 1'b0;
        end else if (w_frame_start) begin
            r_state      <= ACCUM;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: if (w_last_pix) r_state <= DRAIN;
                DRAIN: begin
                    r_state      <= DONE;
                    r_frame_done <= 1'b1;
                end
                DONE:    r_state <= DONE;
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign w_q_box = r_box_tbl[obj_id];
    assign w_sum_x = {1'b0, w_q_box.min_x} + {1'b0, w_q_box.max_x};
    assign w_sum_y = {1'b0, w_q_box.min_y} + {1'b0, w_q_box.max_y};
    assign w_q_hit = r_frame_done && r_valid[obj_id] && (obj_id != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_obj_hit <= 1'b0;
            r_obj_x   <= '0;
            r_obj_y   <= '0;
        end else begin
            r_obj_hit <= w_q_hit;
            r_obj_x   <= w_q_hit ? {{(32-COORD_WIDTH){1'b0}}, w_sum_x[COORD_WIDTH:1]} : 32'd0;
            r_obj_y   <= w_q_hit ? {{(32-COORD_WIDTH){1'b0}}, w_sum_y[COORD_WIDTH:1]} : 32'd0;
        end
    end

    assign frame_done = r_frame_done;
    assign obj_hit    = r_obj_hit;
    assign obj_x      = r_obj_x;
    assign obj_y      = r_obj_y;
endmodule

// File: tb/tb_object_bbox_tracker.sv
// Directed bench for object_bbox_tracker: inputs driven and outputs checked on the falling edge.
module tb_object_bbox_tracker;
    localparam int W  = 160;
    localparam int H  = 120;
    localparam int LW = 8;
    localparam int CW = 11;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          en      = 1'b0;
    logic [31:0]   x       = '0;
    logic [31:0]   y       = '0;
    logic [LW-1:0] label   = '0;
    logic [LW-1:0] obj_id  = '0;
    logic          frame_done;
    logic          obj_hit;
    logic [31:0]   obj_x;
    logic [31:0]   obj_y;

    int n_cmp = 0;
    int n_bad = 0;

    object_bbox_tracker #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .LABEL_WIDTH (LW),
        .COORD_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .x         (x),
        .y         (y),
        .label     (label),
        .obj_id    (obj_id),
        .frame_done(frame_done),
        .obj_hit   (obj_hit),
        .obj_x     (obj_x),
        .obj_y     (obj_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic pix(input int xx, input int yy, input int lab);
        @(negedge clk);
        en    = 1'b1;
        x     = 32'(xx);
        y     = 32'(yy);
        label = LW'(lab);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    task automatic end_frame(input string tag);
        pix(W-1, H-1, 0);
        @(negedge clk);
        en = 1'b0;
        check({tag, ".fd_drain"}, 32'(frame_done), 32'd0);
        @(negedge clk);
        check({tag, ".fd_done"}, 32'(frame_done), 32'd1);
    endtask

    task automatic query(input string tag, input int id, input int hit, input int ex, input int ey);
        en     = 1'b0;
        obj_id = LW'(id);
        @(negedge clk);
        check({tag, ".hit"}, 32'(obj_hit), 32'(hit));
        check({tag, ".x"}, obj_x, 32'(ex));
        check({tag, ".y"}, obj_y, 32'(ey));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst.fd", 32'(frame_done), 32'd0);
        check("rst.hit", 32'(obj_hit), 32'd0);
        check("rst.x", obj_x, 32'd0);
        check("rst.y", obj_y, 32'd0);
        reset_n = 1'b1;

        // Frame A: label 3 on x=1..20, row 0, then 20 more pixels before an async reset.
        pix(0, 0, 0);
        for (int i = 1; i <= 20; i++) pix(i, 0, 3);
        end_frame("fa");
        query("fa.q3", 3, 1, 10, 0);
        for (int i = 1; i <= 20; i++) pix(i, 1, 3);
        @(negedge clk);
        en = 1'b0;
        check("pre_rst.hit", 32'(obj_hit), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst.fd", 32'(frame_done), 32'd0);
        check("mid_rst.hit", 32'(obj_hit), 32'd0);
        check("mid_rst.x", obj_x, 32'd0);
        check("mid_rst.y", obj_y, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        pix(0, 0, 0);
        pix(5, 5, 6);
        end_frame("fa2");
        query("fa2.q3", 3, 0, 0, 0);
        query("fa2.q6", 6, 1, 5, 5);

        // Frame B: sparse label 5 and a continuous run of label 7.
        pix(0, 0, 0);
        pix(10, 4, 5);
        pix(30, 4, 5);
        pix(20, 9, 5);
        for (int i = 100; i <= 107; i++) pix(i, 2, 7);
        end_frame("fb");
        query("fb.q5", 5, 1, 20, 6);
        query("fb.q7", 7, 1, 103, 2);

        // Frame C: label 7 with en toggling every cycle.
        pix(0, 0, 0);
        for (int i = 100; i <= 107; i++) begin
            pix(i, 2, 7);
            gap(1);
        end
        end_frame("fc");
        query("fc.q7", 7, 1, 103, 2);
        query("fc.q5", 5, 0, 0, 0);

        // Frame D: label 7 with 3-cycle gaps.
        pix(0, 0, 0);
        for (int i = 100; i <= 107; i++) begin
            pix(i, 2, 7);
            gap(3);
        end
        end_frame("fd");
        query("fd.q7", 7, 1, 103, 2);

        // Frames E1/E2 back to back: the E1 last-pixel write must not reach E2.
        pix(0, 0, 9);
        pix(W-1, H-1, 9);
        pix(0, 0, 0);
        pix(50, 50, 9);
        gap(2);
        check("fe.fd_abort", 32'(frame_done), 32'd0);
        end_frame("fe");
        query("fe.q9", 9, 1, 50, 50);

        // Frame F: out-of-bounds pixels, early query, background query.
        pix(0, 0, 0);
        pix(W, 5, 4);
        pix(5, H, 4);
        pix(2048 + 10, 4, 4);
        pix(10, 2048 + 4, 4);
        gap(1);
        query("ff.early9", 9, 0, 0, 0);
        end_frame("ff");
        query("ff.q4", 4, 0, 0, 0);
        query("ff.q0", 0, 0, 0, 0);
        query("ff.q9", 9, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
